// File: rtl/sm_frame_accumulator.sv
// Sign-magnitude frame accumulator: sums a frame of sign-magnitude samples in two's complement
// and returns the total in sign-magnitude form. Define SMACC_SAT_EN for a saturating accumulator.
module sm_frame_accumulator #(
  parameter int IN_MAG_W  = 5,
  parameter int ACC_MAG_W = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_MAG_W-1:0]                in_mag,
  input  logic                               in_sign,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_MAG_W-1:0]               out_mag,
  output logic                               out_sign,
  output logic                               out_sat,
  output logic [$clog2(FRAME_LEN+1)-1:0]     out_count
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C  = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic signed [ACC_MAG_W:0]   acc_r, acc_nxt_s, acc_add_s, samp_s;
  logic [ACC_MAG_W:0]          mag_ext_s;
  logic [CNT_W-1:0]            cnt_r, cnt_nxt_s;
  logic                        sat_r, sat_nxt_s, sat_hit_s;
  logic                        in_ready_r, in_ready_nxt_s;
  logic                        out_valid_r, out_valid_nxt_s;
  logic [ACC_MAG_W-1:0]        out_mag_r, out_mag_nxt_s;
  logic                        out_sign_r, out_sign_nxt_s;
  logic                        out_sat_r, out_sat_nxt_s;
  logic [CNT_W-1:0]            out_count_r, out_count_nxt_s;
  logic                        accept_s;

  assign accept_s = in_valid && in_ready_r;

  // Sample to two's complement; negative zero naturally collapses to +0.
  always_comb begin
    mag_ext_s = {{(ACC_MAG_W + 1 - IN_MAG_W){1'b0}}, in_mag};
    samp_s    = in_sign ? -$signed(mag_ext_s) : $signed(mag_ext_s);
  end

`ifdef SMACC_SAT_EN
  localparam int ACC_LIM = (1 << ACC_MAG_W) - 1;
  localparam logic signed [ACC_MAG_W+1:0] SUM_MAX_C = (ACC_MAG_W + 2)'(ACC_LIM);
  localparam logic signed [ACC_MAG_W+1:0] SUM_MIN_C = (ACC_MAG_W + 2)'(-ACC_LIM);
  localparam logic signed [ACC_MAG_W:0]   ACC_MAX_C = (ACC_MAG_W + 1)'(ACC_LIM);
  localparam logic signed [ACC_MAG_W:0]   ACC_MIN_C = (ACC_MAG_W + 1)'(-ACC_LIM);
  logic signed [ACC_MAG_W+1:0] sum_wide_s;

  // Saturating add: one guard bit detects overflow before clamping.
  always_comb begin
    sum_wide_s = (ACC_MAG_W + 2)'(acc_r) + (ACC_MAG_W + 2)'(samp_s);
    if (sum_wide_s > SUM_MAX_C) begin
      acc_add_s = ACC_MAX_C;
      sat_hit_s = 1'b1;
    end else if (sum_wide_s < SUM_MIN_C) begin
      acc_add_s = ACC_MIN_C;
      sat_hit_s = 1'b1;
    end else begin
      acc_add_s = sum_wide_s[ACC_MAG_W:0];
      sat_hit_s = 1'b0;
    end
  end
`else
  // Wrapping add modulo 2^(ACC_MAG_W+1).
  always_comb begin
    acc_add_s = acc_r + samp_s;
    sat_hit_s = 1'b0;
  end
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    sat_nxt_s       = sat_r;
    in_ready_nxt_s  = in_ready_r;
    out_valid_nxt_s = out_valid_r;
    out_mag_nxt_s   = out_mag_r;
    out_sign_nxt_s  = out_sign_r;
    out_sat_nxt_s   = out_sat_r;
    out_count_nxt_s = out_count_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (accept_s) begin
          acc_nxt_s = acc_add_s;
          cnt_nxt_s = cnt_r + CNT_ONE_C;
          sat_nxt_s = sat_r | sat_hit_s;
        end else begin
          acc_nxt_s = acc_r;
        end
        // cnt_nxt_s != 0 covers both "frame already open" and "accept this cycle".
        if ((accept_s && (cnt_nxt_s == FRAME_LEN_C)) || (flush && (cnt_nxt_s != CNT_ZERO_C))) begin
          state_nxt_s     = HOLD;
          in_ready_nxt_s  = 1'b0;
          out_valid_nxt_s = 1'b1;
          out_sign_nxt_s  = acc_nxt_s[ACC_MAG_W];
          out_mag_nxt_s   = acc_nxt_s[ACC_MAG_W] ? ACC_MAG_W'(-acc_nxt_s) : acc_nxt_s[ACC_MAG_W-1:0];
          out_sat_nxt_s   = sat_nxt_s;
          out_count_nxt_s = cnt_nxt_s;
        end else if (cnt_nxt_s != CNT_ZERO_C) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s     = IDLE;
          acc_nxt_s       = '0;
          cnt_nxt_s       = '0;
          sat_nxt_s       = 1'b0;
          in_ready_nxt_s  = 1'b1;
          out_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        acc_nxt_s       = '0;
        cnt_nxt_s       = '0;
        sat_nxt_s       = 1'b0;
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= '0;
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_mag_r   <= '0;
      out_sign_r  <= 1'b0;
      out_sat_r   <= 1'b0;
      out_count_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sat_r       <= sat_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_mag_r   <= out_mag_nxt_s;
      out_sign_r  <= out_sign_nxt_s;
      out_sat_r   <= out_sat_nxt_s;
      out_count_r <= out_count_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_mag   = out_mag_r;
  assign out_sign  = out_sign_r;
  assign out_sat   = out_sat_r;
  assign out_count = out_count_r;

endmodule

// File: tb/tb_sm_frame_accumulator.sv
// Scoreboard bench for sm_frame_accumulator (FRAME_LEN=16, ACC_MAG_W=8).
module tb_sm_frame_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_mag = 5'd0;
  logic       in_sign = 1'b0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_mag;
  logic       out_sign;
  logic       out_sat;
  logic [4:0] out_count;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  sm_frame_accumulator #(.IN_MAG_W(5), .ACC_MAG_W(8), .FRAME_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_sign(in_sign), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_mag(out_mag), .out_sign(out_sign),
    .out_sat(out_sat), .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic rdy, input logic vld, input logic sgn,
                                     input logic sat, input logic [4:0] cnt, input logic [7:0] mag);
    return {15'd0, rdy, vld, sgn, sat, cnt, mag};
  endfunction

  function automatic logic [31:0] frame(input logic sgn, input logic sat,
                                        input logic [4:0] cnt, input logic [7:0] mag);
    return pk(1'b0, 1'b1, sgn, sat, cnt, mag);
  endfunction

  function automatic logic [31:0] dut_state();
    return pk(in_ready, out_valid, out_sign, out_sat, out_count, out_mag);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_frame: got %h expected none", dut_state());
      end else begin
        check("frame", pk(1'b0, out_valid, out_sign, out_sat, out_count, out_mag), exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [4:0] mag, input logic sgn, input logic fl, input logic closes);
    bit got = 1'b0;
    in_valid = 1'b1; in_mag = mag; in_sign = sgn; flush = fl;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0; flush = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; in_mag = 5'd0; in_sign = 1'b0;
      if (closes) begin
        @(negedge clk);
        check("close_latency", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", dut_state(), pk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) send(5'd3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid", dut_state(), pk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(frame(1'b0, 1'b0, 5'd16, 8'd16));
    for (int i = 0; i < 16; i++) send(5'd1, 1'b0, 1'b0, i == 15);

    // Mixed frame: 8x(+31) and 8x(-20) alternating, random gaps -> +88.
    exp_q.push_back(frame(1'b0, 1'b0, 5'd16, 8'd88));
    for (int i = 0; i < 16; i++) begin
      gap();
      send((i % 2 == 0) ? 5'd31 : 5'd20, (i % 2 == 1), 1'b0, i == 15);
    end

    // Lone flush with an empty frame produces nothing.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Negative zero counts as a sample; flush with the third sample closes.
    exp_q.push_back(frame(1'b0, 1'b0, 5'd3, 8'd0));
    send(5'd0, 1'b1, 1'b0, 1'b0);
    gap();
    send(5'd3, 1'b0, 1'b0, 1'b0);
    gap();
    send(5'd3, 1'b1, 1'b1, 1'b1);

    // 16x(+31) = 496: clamps to 255 or wraps to -16.
`ifdef SMACC_SAT_EN
    exp_q.push_back(frame(1'b0, 1'b1, 5'd16, 8'd255));
`else
    exp_q.push_back(frame(1'b1, 1'b0, 5'd16, 8'd16));
`endif
    for (int i = 0; i < 16; i++) send(5'd31, 1'b0, 1'b0, i == 15);
    exp_q.push_back(frame(1'b1, 1'b0, 5'd16, 8'd16));
    for (int i = 0; i < 16; i++) send(5'd1, 1'b1, 1'b0, i == 15);

    // Backpressure: hold for 10 cycles with a sample waiting.
    out_ready = 1'b0;
    exp_q.push_back(frame(1'b0, 1'b0, 5'd4, 8'd20));
    for (int i = 0; i < 3; i++) send(5'd5, 1'b0, 1'b0, 1'b0);
    send(5'd5, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1; in_mag = 5'd7; in_sign = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", dut_state(), pk(1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 8'd20));
      @(posedge clk); #1;
    end
    exp_q.push_back(frame(1'b0, 1'b0, 5'd2, 8'd9));
    out_ready = 1'b1;
    send(5'd7, 1'b0, 1'b0, 1'b0);
    send(5'd2, 1'b0, 1'b1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
